// File: rtl/dot_product_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: FSM encodings and width helpers.
package dot_product_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Accumulator width that cannot overflow for n products of two w-bit operands.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
    return 2 * w + clog2(n);
  endfunction

endpackage

// File: rtl/dot_product_sequencer_mac_unit.sv
// Multiply-accumulate register: acc += a*b on enable; synchronous clear wins over enable.
module mac_unit
  import dot_product_sequencer_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] acc
);

  logic [2*W-1:0]   w_prod;
  logic [ACC_W-1:0] r_acc;

  assign w_prod = a * b;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (enable) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/dot_product_sequencer.sv
// Start/busy/done controller sequencing one mac_unit over N element pairs,
// with valid/ready handshakes on the element input and the result output.
module dot_product_sequencer
  import dot_product_sequencer_pkg::*;
#(
  parameter  int unsigned N     = 3,
  parameter  int unsigned W     = 3,
  localparam int unsigned ACC_W = acc_width(W, N),
  localparam int unsigned CNT_W = clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     element_a,
  input  logic [W-1:0]     element_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             w_start_job;
  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_acc;

  assign w_start_job = (r_state == ST_IDLE) && start;
  assign w_accept    = r_in_ready && in_valid;
  assign w_last      = w_accept && (r_count == CNT_W'(N - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start)     w_next_state = ST_LOAD;
      ST_LOAD: if (w_last)    w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  // Handshake and status flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == ST_LOAD);
      r_out_valid <= (w_next_state == ST_DONE);
      r_busy      <= (w_next_state == ST_LOAD) || (w_next_state == ST_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_start_job) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // The accumulator is frozen outside LOAD, so it doubles as the held result register.
  mac_unit #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_start_job),
    .enable (w_accept),
    .a      (element_a),
    .b      (element_b),
    .acc    (w_acc)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign count     = r_count;
  assign result    = w_acc;

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Controller that sequences a multiply-accumulate datapath to compute the dot product of two N-element unsigned vectors.
- Elements arrive one pair per handshake; the result leaves through its own handshake.
- Replaces free-running, self-timed accumulation with an explicit start, busy and done protocol, so upstream stimulus and downstream consumers can stall safely.
- Sits between the vector source (testbench or memory streamer) and the result consumer.

Parameters:
N, 3, number of elements per vector (N >= 1)
W, 3, width of each unsigned element in bits

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new dot product; sampled only in IDLE
in_valid  input  1  element pair valid
in_ready  output  1  sequencer accepts an element pair this cycle
element_a  input  W  vector 1 element, unsigned
element_b  input  W  vector 2 element, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  ACC_W  dot product, ACC_W = 2*W + clog2(N), unsigned
busy  output  1  high in LOAD or DONE
count  output  clog2(N+1)  element pairs accepted in the current job

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, out_valid=0, result=0, busy=0, count=0, accumulator=0.
- Reset mid-operation aborts the job; no partial result is ever presented.
- Arithmetic: unsigned multiply, W x W -> 2W. Each product is zero-extended to ACC_W before accumulation. ACC_W never overflows, since N*(2^W-1)^2 < 2^ACC_W.

State machine (IDLE, LOAD, DONE):
- IDLE:
  - in_ready=0 and out_valid=0; in_valid is ignored.
  - start=1 -> clear accumulator and count, go to LOAD next cycle.
- LOAD:
  - in_ready=1.
  - On in_valid & in_ready: accumulator += a*b and count += 1.
  - in_valid low stalls with no change.
  - When the accepted pair is the Nth (count==N-1 before the edge) -> go to DONE.
- DONE:
  - out_valid=1, result = final accumulator, in_ready=0.
  - result is held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready -> IDLE; out_valid drops the next cycle.

Timing and boundary conditions:
- Latency: result and out_valid are registered and appear the cycle after the Nth pair handshake.
- Minimum job length is N+2 cycles: start, N loads, 1 done cycle with out_ready=1.
- start outside IDLE is ignored; there is no queueing.
- start and out_ready together in DONE: the handshake completes and start is ignored. A new start is needed once the sequencer is back in IDLE.
- N=1: one accepted pair goes straight to DONE.
- count holds N in DONE. count returns to 0 on the next start or on reset.
- No X is allowed on any output after reset.

Decomposition:
- Shared package, for use by sibling blocks and benches:
  - state enumeration (IDLE=2'd0, LOAD=2'd1, DONE=2'd2)
  - ACC_W width function
  - clog2 helper
- One sub-module, mac_unit (parameters W, ACC_W):
  - inputs: clock, reset, clear, enable, a, b
  - output: acc
  - synchronous clear has priority over enable
- dot_product_sequencer holds the FSM, the element counter, the handshakes and the result register, and instantiates mac_unit.

Test Plan:
1. N=3, W=3. Reset, start, then pairs (1,4),(2,5),(3,6) on consecutive cycles with out_ready=1 -> out_valid=1 with result=32 the cycle after the third pair; out_valid=0 the next cycle; busy=0.
2. All elements 7 -> result=147, with no overflow in the 8-bit result.
3. in_valid toggled 1,0,0,1,0,1 with pairs (2,2),(3,3),(1,7) -> exactly 3 pairs accepted, result=20, and in_ready=1 for the whole LOAD period.
4. Result backpressure: out_ready=0 for 5 cycles in DONE -> result held at the same value with out_valid=1; out_ready=1 -> IDLE the next cycle.
5. start pulses during LOAD and during DONE, and in_valid=1 while in IDLE -> no restart, count is unaffected, and no pair is accepted in IDLE.
6. reset asserted after 2 of 3 pairs -> the next cycle is IDLE with all outputs 0. A new job (1,1),(1,1),(1,1) -> result=3, with no residue from the aborted job.
